alu_wide_sequencer: RTL and testbench

- Shares one 8-bit ALU instance between two requesters.
- Executes 16-bit ADD/SUB/AND/OR/XOR/NAND as two byte passes, low byte first, with the carry chained between passes.
- Sits between the datapath requesters and the ALU. It drives the ALU fn/op_A/op_B/cin inputs and samples out/co/z.
- Only one operation is in flight at a time. Results are returned on a valid/ready response channel.

---
 rtl/alu_wide_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_wide_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs 16-bit ALU operations for two requesters on a shared
// 8-bit ALU, low byte first, then high byte with the carry chained between passes.
// Optional feature macro ALU_SEQ_RR_EN: round-robin arbitration between requesters.
// Without it, requester 0 always has priority.
module alu_wide_sequencer #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [3*N_REQ-1:0] req_op,
  input  logic [W*N_REQ-1:0] req_a,
  input  logic [W*N_REQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [W-1:0]       rsp_result,
  output logic               rsp_co,
  output logic               rsp_z,
  output logic [2:0]         alu_fn,
  output logic [W/2-1:0]     alu_a,
  output logic [W/2-1:0]     alu_b,
  output logic               alu_cin,
  input  logic [W/2-1:0]     alu_out,
  input  logic               alu_co,
  input  logic               alu_z
);

  localparam int unsigned BW = W / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           id_q, id_d;
  logic [BW-1:0]  lo_q, lo_d;
  logic           carry_q, carry_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_co_q, rsp_co_d;
  logic           rsp_z_q, rsp_z_d;

  logic           grant_any;
  logic           grant_id;
  logic           accept;
  logic           is_arith;
  logic           is_sub;
  logic [2:0]     fn_sel;
  logic [W-1:0]   hi_result;

  // The 8-bit zero flag is meaningless for a 16-bit result; z is rebuilt locally.
  logic           unused_alu_z;
  assign unused_alu_z = alu_z;

`ifdef ALU_SEQ_RR_EN
  logic           rr_ptr_q, rr_ptr_d;

  // Arbiter: on contention the pointer picks the winner, otherwise the lone requester wins.
  always_comb begin
    grant_any = |req_valid;
    if (req_valid[0] && req_valid[1]) begin
      grant_id = rr_ptr_q;
    end else begin
      grant_id = ~req_valid[0];
    end
  end

  // Pointer moves to the non-winner after every accept.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = ~grant_id;
    end
  end

  // Round-robin pointer register; reset favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Arbiter: fixed priority, requester 0 always wins.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = ~req_valid[0];
  end
`endif

  assign accept    = (state_q == S_IDLE) && grant_any && !rst;
  assign is_arith  = ~op_q[2];
  assign is_sub    = (op_q[2:1] == 2'b01);
  assign fn_sel    = is_arith ? 3'b000 : op_q;
  assign hi_result = {alu_out, lo_q};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: IDLE -> LO -> HI -> RESP -> IDLE on response handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LO;
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: grant strobe in IDLE and the per-pass ALU drive.
  always_comb begin
    req_ready = '0;
    alu_fn    = 3'b000;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
    case (state_q)
      S_LO: begin
        alu_fn  = fn_sel;
        alu_a   = a_q[BW-1:0];
        alu_b   = is_sub ? ~b_q[BW-1:0] : b_q[BW-1:0];
        alu_cin = is_sub;
      end
      S_HI: begin
        alu_fn  = fn_sel;
        alu_a   = a_q[W-1:BW];
        alu_b   = is_sub ? ~b_q[W-1:BW] : b_q[W-1:BW];
        alu_cin = is_arith & carry_q;
      end
      default: ;
    endcase
  end

  // Datapath next values: latch the request, capture each byte pass, build the response.
  always_comb begin
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    lo_d         = lo_q;
    carry_d      = carry_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_co_d     = rsp_co_q;
    rsp_z_d      = rsp_z_q;
    if (accept) begin
      op_d = grant_id ? req_op[3 +: 3] : req_op[0 +: 3];
      a_d  = grant_id ? req_a[W +: W]  : req_a[0 +: W];
      b_d  = grant_id ? req_b[W +: W]  : req_b[0 +: W];
      id_d = grant_id;
    end
    case (state_q)
      S_LO: begin
        lo_d    = alu_out;
        carry_d = alu_co;
      end
      S_HI: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = hi_result;
        rsp_co_d     = is_arith & alu_co;
        rsp_z_d      = (hi_result == '0);
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      lo_q         <= '0;
      carry_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_co_q     <= 1'b0;
      rsp_z_q      <= 1'b0;
    end else begin
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      lo_q         <= lo_d;
      carry_q      <= carry_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_co_q     <= rsp_co_d;
      rsp_z_q      <= rsp_z_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_co     = rsp_co_q;
  assign rsp_z      = rsp_z_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Testbench for alu_wide_sequencer: models the 8-bit ALU, drives randomized
// operations and compares responses against a 16-bit arithmetic reference.
`timescale 1ns/1ps
module tb_alu_wide_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_co;
  logic        rsp_z;
  logic [2:0]  alu_fn;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_out;
  logic        alu_co;
  logic        alu_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer #(.N_REQ(2), .W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_co(rsp_co), .rsp_z(rsp_z),
    .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z)
  );

  // 8-bit ALU: fn 000 adds with carry, 1xx are the bitwise ops.
  function automatic logic [8:0] alu_model(logic [2:0] fn, logic [7:0] a, logic [7:0] b, logic cin);
    case (fn)
      3'b100:  return {1'b0, a & b};
      3'b101:  return {1'b0, a | b};
      3'b110:  return {1'b0, a ^ b};
      3'b111:  return {1'b0, ~(a & b)};
      default: return 9'({1'b0, a} + {1'b0, b} + 9'(cin));
    endcase
  endfunction

  logic [8:0] alu_r;
  always_comb alu_r = alu_model(alu_fn, alu_a, alu_b, alu_cin);
  assign alu_out = alu_r[7:0];
  assign alu_co  = alu_r[8];
  assign alu_z   = (alu_r[7:0] == 8'h00);

  // Reference: whole 16-bit operation, returns {co, z, result}.
  function automatic logic [17:0] ref_model(logic [2:0] op, logic [15:0] a, logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      3'b000, 3'b001: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      3'b010, 3'b011: begin r = a - b; c = (a >= b); end
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return {c, (r == 16'h0000), r};
  endfunction

  // One complete transaction from IDLE; returns what the DUT reported.
  task automatic do_op(input int id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic co, output logic z, output logic rid,
                       output int lat, output logic rok);
    req_op[3*id +: 3] = op;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_valid = '0;
    req_valid[id] = 1'b1;
    #1;
    rok = (req_ready === 2'(1 << id));
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = rsp_result; co = rsp_co; z = rsp_z; rid = rsp_id;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_co, rsp_z} !== 4'b0000) begin
      errors++; $display("FAIL reset_rsp_flags got=%b exp=0000", {rsp_valid, rsp_id, rsp_co, rsp_z});
    end
    checks++;
    if (rsp_result !== 16'h0000) begin
      errors++; $display("FAIL reset_rsp_result got=%h exp=0000", rsp_result);
    end
    checks++;
    if ({alu_fn, alu_a, alu_b, alu_cin} !== 20'h0) begin
      errors++; $display("FAIL reset_alu_drive got=%h exp=00000", {alu_fn, alu_a, alu_b, alu_cin});
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [15:0] r, a, b;
    logic co, z, id, rok;
    logic [2:0] op;
    logic [17:0] e;
    int lat, idr;
    do_op(0, 3'b000, 16'h00FF, 16'h0001, r, co, z, id, lat, rok);
    checks++;
    if (rok !== 1'b1) begin errors++; $display("FAIL add_req_ready got=%b exp=1", rok); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++;
    if ({id, co, z, r} !== {1'b0, 1'b0, 1'b0, 16'h0100}) begin
      errors++; $display("FAIL add_known got=%h exp=%h", {id, co, z, r}, {3'b000, 16'h0100});
    end
    do_op(1, 3'b001, 16'hFFFF, 16'h0001, r, co, z, id, lat, rok);
    checks++;
    if ({id, co, z, r} !== {1'b1, 1'b1, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL add_wrap got=%h exp=%h", {id, co, z, r}, {3'b111, 16'h0000});
    end
    for (int k = 0; k < 6; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      op = 3'($urandom_range(0, 1)); idr = int'($urandom_range(0, 1));
      do_op(idr, op, a, b, r, co, z, id, lat, rok);
      e = ref_model(op, a, b);
      checks++;
      if ({id, co, z, r} !== {1'(idr), e}) begin
        errors++; $display("FAIL add_rand a=%h b=%h got=%h exp=%h", a, b, {id, co, z, r}, {1'(idr), e});
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] r, a, b;
    logic co, z, id, rok;
    logic [17:0] e;
    int lat, idr;
    do_op(1, 3'b010, 16'h1234, 16'h1234, r, co, z, id, lat, rok);
    checks++;
    if ({id, co, z, r} !== {1'b1, 1'b1, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL sub_equal got=%h exp=%h", {id, co, z, r}, {3'b111, 16'h0000});
    end
    do_op(1, 3'b011, 16'h0001, 16'h0002, r, co, z, id, lat, rok);
    checks++;
    if ({id, co, z, r} !== {1'b1, 1'b0, 1'b0, 16'hFFFF}) begin
      errors++; $display("FAIL sub_borrow got=%h exp=%h", {id, co, z, r}, {3'b100, 16'hFFFF});
    end
    for (int k = 0; k < 6; k++) begin
      a = 16'($urandom); b = (k == 0) ? a : 16'($urandom);
      idr = int'($urandom_range(0, 1));
      do_op(idr, 3'b010, a, b, r, co, z, id, lat, rok);
      e = ref_model(3'b010, a, b);
      checks++;
      if ({id, co, z, r} !== {1'(idr), e}) begin
        errors++; $display("FAIL sub_rand a=%h b=%h got=%h exp=%h", a, b, {id, co, z, r}, {1'(idr), e});
      end
    end
  endtask

  task automatic test_logic();
    logic [15:0] r, a, b;
    logic co, z, id, rok;
    logic [2:0] op;
    logic [17:0] e;
    int lat, idr;
    do_op(0, 3'b100, 16'hF0F0, 16'h0FF0, r, co, z, id, lat, rok);
    checks++;
    if ({co, z, r} !== {1'b0, 1'b0, 16'h00F0}) begin
      errors++; $display("FAIL and_known got=%h exp=%h", {co, z, r}, {2'b00, 16'h00F0});
    end
    do_op(1, 3'b111, 16'hFFFF, 16'hFFFF, r, co, z, id, lat, rok);
    checks++;
    if ({id, co, z, r} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL nand_known got=%h exp=%h", {id, co, z, r}, {3'b101, 16'h0000});
    end
    for (int k = 0; k < 8; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      op = 3'($urandom_range(4, 7)); idr = int'($urandom_range(0, 1));
      do_op(idr, op, a, b, r, co, z, id, lat, rok);
      e = ref_model(op, a, b);
      checks++;
      if ({id, co, z, r} !== {1'(idr), e}) begin
        errors++; $display("FAIL logic_rand op=%0d got=%h exp=%h", op, {id, co, z, r}, {1'(idr), e});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  bop[2][4];
    logic [15:0] ba[2][4];
    logic [15:0] bb[2][4];
    int idx[2], ridx[2], ids[8];
    int nrsp, rid;
    logic [1:0] granted;
    logic [17:0] e;
    for (int i = 0; i < 2; i++) begin
      idx[i] = 0; ridx[i] = 0;
      for (int j = 0; j < 4; j++) begin
        bop[i][j] = 3'($urandom_range(0, 7));
        ba[i][j] = 16'($urandom); bb[i][j] = 16'($urandom);
      end
    end
    nrsp = 0; granted = 2'b00;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && nrsp < 8; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (granted[i]) idx[i]++;
      if (rsp_valid === 1'b1) begin
        rid = int'(rsp_id);
        ids[nrsp] = rid;
        if (ridx[rid] < 4) begin
          e = ref_model(bop[rid][ridx[rid]], ba[rid][ridx[rid]], bb[rid][ridx[rid]]);
          checks++;
          if ({rsp_co, rsp_z, rsp_result} !== e) begin
            errors++; $display("FAIL b2b_result id=%0d got=%h exp=%h", rid, {rsp_co, rsp_z, rsp_result}, e);
          end
          ridx[rid]++;
        end
        nrsp++;
      end
      for (int i = 0; i < 2; i++) begin
        if (idx[i] < 4) begin
          req_valid[i] = 1'b1;
          req_op[3*i +: 3] = bop[i][idx[i]];
          req_a[16*i +: 16] = ba[i][idx[i]];
          req_b[16*i +: 16] = bb[i][idx[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      granted = req_ready;
      if (granted == 2'b11) begin
        checks++; errors++; $display("FAIL b2b_onehot got=%b exp=one-hot", granted);
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    checks++;
    if (nrsp != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", nrsp); end
    for (int k = 0; k < 8 && k < nrsp; k++) begin
`ifdef ALU_SEQ_RR_EN
      if (k > 0) begin
        checks++;
        if (ids[k] == ids[k-1]) begin
          errors++; $display("FAIL b2b_rr_order idx=%0d got=%0d exp=%0d", k, ids[k], 1 - ids[k-1]);
        end
      end
`else
      checks++;
      if (ids[k] != ((k >= 4) ? 1 : 0)) begin
        errors++; $display("FAIL b2b_prio_order idx=%0d got=%0d exp=%0d", k, ids[k], (k >= 4) ? 1 : 0);
      end
`endif
    end
  endtask

  task automatic test_stall();
    logic [15:0] a, b, a2, b2;
    logic [17:0] e, e2;
    a = 16'($urandom); b = 16'($urandom); e = ref_model(3'b000, a, b);
    a2 = 16'($urandom); b2 = 16'($urandom); e2 = ref_model(3'b010, a2, b2);
    req_op[2:0] = 3'b000; req_a[15:0] = a; req_b[15:0] = b;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_co, rsp_z, rsp_result} !== {1'b1, 1'b0, e}) begin
      errors++; $display("FAIL stall_first got=%h exp=%h", {rsp_valid, rsp_id, rsp_co, rsp_z, rsp_result}, {2'b10, e});
    end
    req_op[5:3] = 3'b010; req_a[31:16] = a2; req_b[31:16] = b2;
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_co, rsp_z, rsp_result} !== {1'b1, 1'b0, e}) begin
        errors++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", k, {rsp_valid, rsp_id, rsp_co, rsp_z, rsp_result}, {2'b10, e});
      end
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL stall_req_ready cyc=%0d got=%b exp=00", k, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 3'b010) begin
      errors++; $display("FAIL stall_release got=%b exp=010", {rsp_valid, req_ready});
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_co, rsp_z, rsp_result} !== {1'b1, 1'b1, e2}) begin
      errors++; $display("FAIL stall_next got=%h exp=%h", {rsp_valid, rsp_id, rsp_co, rsp_z, rsp_result}, {2'b11, e2});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic co, z, id, rok, seen;
    int lat;
    do_op(1, 3'b101, 16'h1200, 16'h0034, r, co, z, id, lat, rok);
    checks++;
    if ({id, co, z, r} !== {1'b1, 1'b0, 1'b0, 16'h1234}) begin
      errors++; $display("FAIL rmid_pre got=%h exp=%h", {id, co, z, r}, {3'b100, 16'h1234});
    end
    req_op[2:0] = 3'b000; req_a[15:0] = 16'h1111; req_b[15:0] = 16'h2222;
    req_valid = 2'b01;
    #1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_co, rsp_z, rsp_result} !== 20'h0) begin
      errors++; $display("FAIL rmid_rsp got=%h exp=00000", {rsp_valid, rsp_id, rsp_co, rsp_z, rsp_result});
    end
    checks++;
    if ({req_ready, alu_fn, alu_a, alu_b, alu_cin} !== 22'h0) begin
      errors++; $display("FAIL rmid_drive got=%h exp=000000", {req_ready, alu_fn, alu_a, alu_b, alu_cin});
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp got=%b exp=0", seen); end
    do_op(0, 3'b000, 16'h7FFF, 16'h0001, r, co, z, id, lat, rok);
    checks++;
    if ({id, co, z, r} !== {1'b0, 1'b0, 1'b0, 16'h8000}) begin
      errors++; $display("FAIL rmid_fresh got=%h exp=%h", {id, co, z, r}, {3'b000, 16'h8000});
    end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL rmid_latency got=%0d exp=2", lat); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
